// File: rtl/bus_sequencer_pkg.sv
// bus_sequencer_pkg: shared types for the sequencer read-data collector
// (FSM states, FIFO word layout, lane-mask helper).
package bus_sequencer_pkg;

    localparam int RDC_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FLUSH_STAGE,
        FLUSH_PART
    } rdc_state_e;

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } rdc_word_t;

    // Byte-lane mask for a partial word holding n bytes in lanes 0..n-1.
    function automatic logic [3:0] rdc_keep_mask(input logic [1:0] n);
        logic [3:0] mask;
        case (n)
            2'd0:    mask = 4'h0;
            2'd1:    mask = 4'h1;
            2'd2:    mask = 4'h3;
            default: mask = 4'h7;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/rdc_sync_fifo.sv
// rdc_sync_fifo: single-clock show-ahead FIFO. Pointers carry an extra wrap
// bit so full/empty/level come straight from the pointer difference. The
// head entry is read combinationally (small distributed RAM) and forced to
// zero while empty so the output is defined from reset.
module rdc_sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             wr_ok;
    logic             rd_ok;

    assign level = wr_ptr_reg - rd_ptr_reg;
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (level == (AW + 1)'(DEPTH));

    // A write into a full FIFO is still taken when the head leaves this cycle.
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    // Storage array: no reset, contents become unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rdata_collector.sv
// bus_rdata_collector: packs the sequencer's read-byte stream little-endian
// into 32-bit words, buffers them in a FIFO and presents them on an
// AXI-Stream-style master port with tlast on the final word of each run.
// A completed word waits in a stage register until either the next byte
// arrives (written with last=0) or the run ends (last decided by whether a
// partial word follows), so there is never more than one FIFO write per cycle.
// Optional feature macro: BUS_RDATA_STATS_EN adds seq_bytes_o.
module bus_rdata_collector
    import bus_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [7:0]                  bus_data_i,
    input  logic                        bus_data_valid_i,
    input  logic                        seq_start_i,
    input  logic                        seq_ready_i,
    output logic [31:0]                 m_tdata_o,
    output logic [3:0]                  m_tkeep_o,
    output logic                        m_tlast_o,
    output logic                        m_tvalid_o,
    input  logic                        m_tready_i,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic                        overflow_o
`ifdef BUS_RDATA_STATS_EN
    ,
    output logic [15:0]                 seq_bytes_o
`endif
);
    localparam int WORD_W = $bits(rdc_word_t);

    rdc_state_e  state_reg, state_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [31:0] lane_reg, lane_next;
    rdc_word_t   stage_reg, stage_next;
    logic        stage_v_reg, stage_v_next;
    logic        pend_reg, pend_next;
    logic        ready_q_reg;
    logic        overflow_reg, overflow_next;

    logic        ready_rise;
    logic        start_collect;
    logic        wr_en;
    rdc_word_t   wr_word;
    rdc_word_t   rd_word;
    logic        rd_en;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] lane_in;

    assign ready_rise = seq_ready_i & ~ready_q_reg;

    // Current partial word with the incoming byte dropped into lane cnt.
    for (genvar gi = 0; gi < RDC_WORD_BYTES; gi++) begin : g_lane
        assign lane_in[8*gi +: 8] = (cnt_reg == 2'(gi)) ? bus_data_i : lane_reg[8*gi +: 8];
    end

    // Next-state logic: packing, stage hand-off, run flush and FIFO write.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        lane_next     = lane_reg;
        stage_next    = stage_reg;
        stage_v_next  = stage_v_reg;
        pend_next     = pend_reg;
        start_collect = 1'b0;
        wr_en         = 1'b0;
        wr_word       = '0;

        case (state_reg)
            IDLE: begin
                if (seq_start_i) begin
                    state_next    = COLLECT;
                    start_collect = 1'b1;
                end
            end
            COLLECT: begin
                if (bus_data_valid_i) begin
                    if (stage_v_reg) begin
                        wr_en        = 1'b1;
                        wr_word      = stage_reg;
                        wr_word.last = 1'b0;
                        stage_v_next = 1'b0;
                    end
                    if (cnt_reg == 2'd3) begin
                        stage_next.last = 1'b0;
                        stage_next.keep = 4'hF;
                        stage_next.data = lane_in;
                        stage_v_next    = 1'b1;
                        lane_next       = '0;
                    end else begin
                        lane_next = lane_in;
                    end
                    cnt_next = cnt_reg + 2'd1;
                end
                if (ready_rise) begin
                    state_next = FLUSH_STAGE;
                end
            end
            FLUSH_STAGE: begin
                if (seq_start_i) begin
                    pend_next = 1'b1;
                end
                if (stage_v_reg) begin
                    wr_en        = 1'b1;
                    wr_word      = stage_reg;
                    wr_word.last = (cnt_reg == 2'd0);
                    stage_v_next = 1'b0;
                end
                state_next = FLUSH_PART;
            end
            FLUSH_PART: begin
                if (cnt_reg != 2'd0) begin
                    wr_en        = 1'b1;
                    wr_word.last = 1'b1;
                    wr_word.keep = rdc_keep_mask(cnt_reg);
                    wr_word.data = lane_reg;
                end
                cnt_next  = '0;
                lane_next = '0;
                if (pend_reg || seq_start_i) begin
                    state_next    = COLLECT;
                    start_collect = 1'b1;
                    pend_next     = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (start_collect) begin
            cnt_next     = '0;
            lane_next    = '0;
            stage_next   = '0;
            stage_v_next = 1'b0;
        end
    end

    // Overflow flag: cleared when a new run starts, set on any dropped word
    // (a drop in the same cycle wins so the loss is never hidden).
    always_comb begin
        overflow_next = overflow_reg;
        if (start_collect) begin
            overflow_next = 1'b0;
        end
        if (wr_en && fifo_full && !rd_en) begin
            overflow_next = 1'b1;
        end
    end

    // State registers; ready history resets high so no false run end.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            lane_reg     <= '0;
            stage_reg    <= '0;
            stage_v_reg  <= 1'b0;
            pend_reg     <= 1'b0;
            ready_q_reg  <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            lane_reg     <= lane_next;
            stage_reg    <= stage_next;
            stage_v_reg  <= stage_v_next;
            pend_reg     <= pend_next;
            ready_q_reg  <= seq_ready_i;
            overflow_reg <= overflow_next;
        end
    end

    rdc_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (wr_en),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level_o)
    );

    assign m_tvalid_o = ~fifo_empty;
    assign rd_en      = m_tvalid_o & m_tready_i;
    assign m_tdata_o  = rd_word.data;
    assign m_tkeep_o  = rd_word.keep;
    assign m_tlast_o  = rd_word.last;
    assign overflow_o = overflow_reg;

`ifdef BUS_RDATA_STATS_EN
    logic [15:0] byte_cnt_reg, byte_cnt_next;
    logic [15:0] seq_bytes_reg;

    // Saturating count of bytes accepted in the current run.
    always_comb begin
        byte_cnt_next = byte_cnt_reg;
        if (start_collect) begin
            byte_cnt_next = '0;
        end else if (state_reg == COLLECT && bus_data_valid_i && byte_cnt_reg != 16'hFFFF) begin
            byte_cnt_next = byte_cnt_reg + 16'd1;
        end
    end

    // Run byte count latched as the run ends, including a byte on the edge cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_cnt_reg  <= '0;
            seq_bytes_reg <= '0;
        end else begin
            byte_cnt_reg <= byte_cnt_next;
            if (state_reg == COLLECT && state_next == FLUSH_STAGE) begin
                seq_bytes_reg <= byte_cnt_next;
            end
        end
    end

    assign seq_bytes_o = seq_bytes_reg;
`endif

endmodule

// File: tb/tb_bus_rdata_collector.sv
// tb_bus_rdata_collector: directed and randomized runs of the read-data
// collector, compared every cycle against a byte-list/queue model.
module tb_bus_rdata_collector;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  bus_data = '0;
    logic        bus_valid = 1'b0;
    logic        seq_start = 1'b0;
    logic        seq_ready = 1'b1;
    logic        m_tready = 1'b0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic [3:0]  level;
    logic        overflow;
`ifdef BUS_RDATA_STATS_EN
    logic [15:0] seq_bytes;
`endif

    bus_rdata_collector #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .bus_data_i       (bus_data),
        .bus_data_valid_i (bus_valid),
        .seq_start_i      (seq_start),
        .seq_ready_i      (seq_ready),
        .m_tdata_o        (m_tdata),
        .m_tkeep_o        (m_tkeep),
        .m_tlast_o        (m_tlast),
        .m_tvalid_o       (m_tvalid),
        .m_tready_i       (m_tready),
        .level_o          (level),
        .overflow_o       (overflow)
`ifdef BUS_RDATA_STATS_EN
        ,
        .seq_bytes_o      (seq_bytes)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit rand_ready = 1'b0;
    logic [7:0] bq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Phases: 0 idle, 1 collecting, 2 first flush cycle, 3 second flush cycle.
    int          ph = 0;
    logic [7:0]  run_q[$];
    int          emitted = 0;
    bit          pend = 1'b0;
    bit          rdy_prev = 1'b1;
    bit          ovf = 1'b0;
    logic [36:0] fq[$];
    int          mseq_bytes = 0;

    // Word idx of the current run: bytes 4*idx.. little-endian, keep per present byte.
    function automatic logic [36:0] make_word(input int idx, input bit last);
        logic [31:0] d = '0;
        logic [3:0]  k = '0;
        for (int j = 0; j < 4; j++) begin
            if (4 * idx + j < run_q.size()) begin
                d[8*j +: 8] = run_q[4*idx + j];
                k[j] = 1'b1;
            end
        end
        return {last, k, d};
    endfunction

    task automatic model_step();
        bit rd = (fq.size() > 0) && m_tready;
        bit have_w = 1'b0;
        bit start_c = 1'b0;
        logic [36:0] w = '0;
        int nph = ph;
        int n;
        bit rise = seq_ready && !rdy_prev;
        case (ph)
            0: if (seq_start) begin nph = 1; start_c = 1'b1; end
            1: begin
                if (bus_valid) begin
                    n = run_q.size();
                    if (n > 0 && n % 4 == 0 && emitted < n / 4) begin
                        w = make_word(n / 4 - 1, 1'b0); have_w = 1'b1; emitted++;
                    end
                    run_q.push_back(bus_data);
                end
                if (rise) begin
                    nph = 2;
                    mseq_bytes = (run_q.size() > 65535) ? 65535 : run_q.size();
                end
            end
            2: begin
                if (seq_start) pend = 1'b1;
                n = run_q.size();
                if (n >= 4 && emitted < n / 4) begin
                    w = make_word(n / 4 - 1, n % 4 == 0); have_w = 1'b1; emitted++;
                end
                nph = 3;
            end
            default: begin
                n = run_q.size();
                if (n % 4 != 0) begin w = make_word(n / 4, 1'b1); have_w = 1'b1; end
                if (pend || seq_start) begin nph = 1; start_c = 1'b1; pend = 1'b0; end
                else nph = 0;
            end
        endcase
        if (start_c) begin run_q.delete(); emitted = 0; ovf = 1'b0; end
        if (have_w && !(fq.size() < DEPTH || rd)) ovf = 1'b1;
        if (rd) void'(fq.pop_front());
        if (have_w && fq.size() < DEPTH) fq.push_back(w);
        rdy_prev = seq_ready;
        ph = nph;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = 0; run_q.delete(); emitted = 0; pend = 1'b0;
            rdy_prev = 1'b1; ovf = 1'b0; fq.delete(); mseq_bytes = 0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("tvalid", 64'(m_tvalid), 64'(fq.size() != 0));
        check("level", 64'(level), 64'(fq.size()));
        check("overflow", 64'(overflow), 64'(ovf));
        if (fq.size() != 0) begin
            check("tdata", 64'(m_tdata), 64'(fq[0][31:0]));
            check("tkeep", 64'(m_tkeep), 64'(fq[0][35:32]));
            check("tlast", 64'(m_tlast), 64'(fq[0][36]));
        end
`ifdef BUS_RDATA_STATS_EN
        check("seq_bytes", 64'(seq_bytes), 64'(mseq_bytes));
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        bus_valid = 1'b0;
        seq_start = 1'b0;
        if (rand_ready) m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic begin_run();
        tick(); seq_start = 1'b1; seq_ready = 1'b1;
        tick(); seq_ready = 1'b0;
    endtask

    task automatic send_bytes(input int gap_pct, input bit noise, input int skip_last);
        for (int i = 0; i < bq.size() - skip_last; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                tick();
                if (noise && $urandom_range(0, 9) == 0) seq_start = 1'b1;
            end
            tick(); bus_valid = 1'b1; bus_data = bq[i];
        end
    endtask

    task automatic end_run(input bit last_at_rise, input int restart);
        tick(); seq_ready = 1'b1;
        if (last_at_rise && bq.size() > 0) begin
            bus_valid = 1'b1; bus_data = bq[bq.size() - 1];
        end
        if (restart != 0) begin
            tick(); if (restart == 1) seq_start = 1'b1;
            tick(); if (restart == 2) seq_start = 1'b1; seq_ready = 1'b0;
        end else begin
            repeat (3) tick();
        end
    endtask

    task automatic expect_head(input string tag, input int lvl, input logic [31:0] d,
                               input logic [3:0] k, input logic l);
        check({tag, ".level"}, 64'(level), 64'(lvl));
        check({tag, ".tvalid"}, 64'(m_tvalid), 64'(lvl != 0));
        check({tag, ".tdata"}, 64'(m_tdata), 64'(d));
        check({tag, ".tkeep"}, 64'(m_tkeep), 64'(k));
        check({tag, ".tlast"}, 64'(m_tlast), 64'(l));
    endtask

    task automatic pop_one();
        tick(); m_tready = 1'b1;
        tick(); m_tready = 1'b0;
    endtask

    task automatic drain();
        m_tready = 1'b1;
        repeat (DEPTH + 2) tick();
        m_tready = 1'b0;
    endtask

    initial begin
        bit lar;
        int rs;
        bit in_run;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst.tvalid", 64'(m_tvalid), 64'd0);
        check("rst.level", 64'(level), 64'd0);
        check("rst.overflow", 64'(overflow), 64'd0);
        check("rst.tdata", 64'(m_tdata), 64'd0);
        check("rst.tkeep", 64'(m_tkeep), 64'd0);
        check("rst.tlast", 64'(m_tlast), 64'd0);
        tick(); rst = 1'b0;

        // Four bytes: one full final word
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        begin_run(); send_bytes(0, 0, 0); end_run(0, 0); tick();
        expect_head("run4", 1, 32'h44332211, 4'hF, 1'b1);
        drain();

        // Six bytes: full word then partial last word
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        begin_run(); send_bytes(0, 0, 0); end_run(0, 0); tick();
        expect_head("run6.b1", 2, 32'h04030201, 4'hF, 1'b0);
        pop_one();
        expect_head("run6.b2", 1, 32'h00000605, 4'h3, 1'b1);
        drain();

        // Empty run
        bq.delete();
        begin_run(); end_run(0, 0); tick();
        check("empty.level", 64'(level), 64'd0);
        check("empty.tvalid", 64'(m_tvalid), 64'd0);

        // Overflow with a stalled consumer
        bq.delete();
        for (int i = 1; i <= 40; i++) bq.push_back(8'(i));
        begin_run(); send_bytes(0, 0, 0); end_run(0, 0); tick();
        check("ovf.level", 64'(level), 64'd8);
        check("ovf.flag", 64'(overflow), 64'd1);
        m_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            expect_head($sformatf("ovf.beat%0d", k), 8 - k,
                        {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)}, 4'hF, 1'b0);
            tick();
        end
        m_tready = 1'b0;
        check("ovf.drained", 64'(level), 64'd0);
        bq.delete();
        begin_run();
        check("ovf.cleared", 64'(overflow), 64'd0);
        end_run(0, 0);

        // Byte on the ready edge, new start one cycle later
        bq = '{8'hA1, 8'hA2, 8'hA3};
        begin_run(); send_bytes(0, 0, 1); end_run(1, 1);
        bq = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        send_bytes(0, 0, 0); end_run(0, 0); tick();
        expect_head("edge.b1", 2, 32'h00A3A2A1, 4'h7, 1'b1);
        pop_one();
        expect_head("edge.b2", 1, 32'hB4B3B2B1, 4'hF, 1'b1);
        drain();

        // Reset mid-run: 3 entries queued, 2 bytes packed
        bq.delete();
        for (int i = 0; i < 14; i++) bq.push_back(8'(8'h80 + i));
        begin_run(); send_bytes(0, 0, 0); tick();
        check("prerst.level", 64'(level), 64'd3);
        #2 rst = 1'b1;
        #1;
        check("midrst.tvalid", 64'(m_tvalid), 64'd0);
        check("midrst.level", 64'(level), 64'd0);
        tick(); seq_ready = 1'b1; rst = 1'b0;
        bq = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        begin_run(); send_bytes(0, 0, 0); end_run(0, 0); tick();
        expect_head("postrst", 1, 32'h8D7C6B5A, 4'hF, 1'b1);
        drain();

        // Randomized runs with a random consumer
        rand_ready = 1'b1;
        in_run = 1'b0;
        for (int r = 0; r < 40; r++) begin
            bq.delete();
            for (int i = 0; i < $urandom_range(0, 20); i++) bq.push_back(8'($urandom));
            lar = (bq.size() > 0) && ($urandom_range(0, 1) == 1);
            rs  = (r == 39) ? 0 : $urandom_range(0, 2);
            if (!in_run) begin_run();
            send_bytes($urandom_range(0, 50), 1'b1, lar ? 1 : 0);
            end_run(lar, rs);
            in_run = (rs != 0);
        end
        rand_ready = 1'b0;
        drain();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_rdata_collector.md
# bus_rdata_collector

Downstream companion of `bus_sequencer_top`: it consumes the sequencer's read-byte stream (`bus_data_o` / `bus_data_valid_o`) and packs bytes little-endian into 32-bit words. Words are buffered in a small FIFO and presented on an AXI-Stream-style master port, with `tlast` marking the final word of each sequence run. It also watches the sequencer's `start_i` and `ready_o` handshake to delimit runs.

## Interface
- `FIFO_DEPTH`, 8: FIFO depth in 37-bit entries; power of two, ≥ 2.
- `clk_i`  in  1  system clock, same domain as `bus_sequencer_top`.
- `rst_i`  in  1  asynchronous, active-high reset.
- `bus_data_i`  in  8  read byte, driven from sequencer `bus_data_o`.
- `bus_data_valid_i`  in  1  one-cycle strobe per byte.
- `seq_start_i`  in  1  copy of the sequencer `start_i` pulse.
- `seq_ready_i`  in  1  sequencer `ready_o`.
- `m_tdata_o`  out  32  packed word; byte k on bits [8k+7:8k].
- `m_tkeep_o`  out  4  valid byte lanes.
- `m_tlast_o`  out  1  last word of the run.
- `m_tvalid_o`  out  1  FIFO not empty.
- `m_tready_i`  in  1  consumer accepts.
- `level_o`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `overflow_o`  out  1  sticky flag: a word was dropped because the FIFO was full.

## Operation
- FSM states:
  - IDLE: bytes are ignored. `seq_start_i` moves the FSM to COLLECT, clears the byte counter, lane register and stage, and clears `overflow_o`.
  - COLLECT: each valid byte is written to lane `cnt`, and `cnt` increments modulo 4. When `cnt` wraps from 3 to 0, the full word {data, keep=4'hF} moves to the stage register and `stage_v` is set.
  - Stage write on next byte: any valid byte arriving while `stage_v`=1 first writes the stage to the FIFO with last=0 in that cycle, then loads its own lane.
  - End of run: a rising edge of `seq_ready_i` (input high, previous-cycle register low) moves the FSM to FLUSH_STAGE. A byte that is valid in the same edge cycle is still accepted.
  - FLUSH_STAGE: if `stage_v`=1, the stage is written with `last = (cnt==0)`. The FSM then goes to FLUSH_PART.
  - FLUSH_PART: if `cnt`>0, the partial word is written with keep = (1<<cnt)-1, unused lanes 0, and last=1. The FSM then goes to IDLE, or straight to COLLECT if a start is pending.
- Empty run (no bytes): nothing is written to the FIFO.
- `seq_start_i` during FLUSH_STAGE/FLUSH_PART: latched as pending and honoured on exit from FLUSH_PART.
- `seq_start_i` during COLLECT: ignored.
- FIFO full on any write: the entry is discarded and `overflow_o` is set. Packing continues.
- FIFO read: occurs when `m_tvalid_o` && `m_tready_i`. A simultaneous read and write on a full FIFO succeeds; no overflow.

## Timing
- Reset values: `m_tdata_o`=0, `m_tkeep_o`=0, `m_tlast_o`=0, `m_tvalid_o`=0, `level_o`=0, `overflow_o`=0. FSM=IDLE, `cnt`=0, `stage_v`=0, no pending start, `seq_ready` register=1 (a run cannot end falsely right after reset).
- A FIFO write committed at edge N makes `m_tvalid_o` high after edge N. The FIFO has show-ahead output.
- `seq_ready_i` rises in cycle N: FLUSH_STAGE is active in cycle N+1 and FLUSH_PART in cycle N+2. The FSM is in IDLE/COLLECT from cycle N+3.
- Throughput: one byte per cycle sustained. At most one FIFO write per cycle, guaranteed by the FSM ordering.
- Reset asserted mid-run: all state and FIFO contents are lost immediately. Outputs take their reset values asynchronously.

## Configuration
- `BUS_RDATA_STATS_EN` defined: adds output `seq_bytes_o[15:0]`, the number of bytes received in the most recent run.
  - Saturates at 16'hFFFF.
  - Latched on entry to FLUSH_STAGE; reset value 0.
  - The running counter clears on the start into COLLECT.
- `BUS_RDATA_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `bus_sequencer_pkg`:
  - FSM state enum `rdc_state_e` (IDLE, COLLECT, FLUSH_STAGE, FLUSH_PART).
  - Packed struct `rdc_word_t` {last, keep[3:0], data[31:0]}.
  - Constant `RDC_WORD_BYTES`=4.
- One sub-module, `rdc_sync_fifo`:
  - Parameterised width/depth.
  - Show-ahead output; registered pointers with an extra wrap bit.
  - Provides full/empty/level.

## Test plan
- Run with 4 bytes 11,22,33,44 → one beat: tdata=32'h44332211, keep=F, last=1.
- Run with 6 bytes 01..06 → beat 1: 32'h04030201, keep=F, last=0. Beat 2: 32'h00000605, keep=3, last=1.
- Run with 0 bytes (start, then `ready` falls and rises) → no beat; `level_o` stays 0.
- `m_tready_i`=0, run of 40 bytes with FIFO_DEPTH=8 → `level_o`=8, `overflow_o`=1. The first 8 beats read back intact. The next `seq_start_i` clears `overflow_o`.
- Byte valid in the same cycle as the `seq_ready_i` rise, plus `seq_start_i` in cycle N+1 → the byte is included in the final beat, and COLLECT is entered in cycle N+3.
- Reset asserted mid-run with 2 bytes packed and 3 FIFO entries → `m_tvalid_o`=0 and `level_o`=0 immediately. The next run packs from lane 0.
